// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD text path: FSM states, LCD command bytes, ASCII control codes.
package lcd_pkg;

  typedef enum logic [2:0] {
    INIT_CLR  = 3'd0,
    INIT_HOME = 3'd1,
    IDLE      = 3'd2,
    EMIT_ADDR = 3'd3,
    EMIT_CHAR = 3'd4,
    EMIT_CLR  = 3'd5
  } state_t;

  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_LINE1 = 8'h80;
  localparam logic [7:0] LCD_LINE2 = 8'hC0;

  localparam logic [7:0] ASCII_LF        = 8'h0A;
  localparam logic [7:0] ASCII_CR        = 8'h0D;
  localparam logic [7:0] ASCII_FF        = 8'h0C;
  localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
  localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_PRINT_MIN) && (b <= ASCII_PRINT_MAX);
  endfunction

endpackage

// File: rtl/lcd_char_fifo.sv
// Character FIFO; rd_data is a register that always holds the head entry while !empty.
// Push is ignored when full, pop ignored when empty; flags are registered.
module lcd_char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] wr_data,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, head_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          do_push, do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_nxt = do_pop ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + CW'(1);
    else if (do_pop && !do_push)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      rd_data <= 8'h00;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= head_nxt;
      count  <= count_nxt;
      full   <= (count_nxt == CW'(DEPTH));
      empty  <= (count_nxt == '0);
      // Bypass the write when it lands in the slot that becomes the new head.
      rd_data <= (do_push && (wr_ptr == head_nxt)) ? wr_data : mem[head_nxt];
    end
  end

endmodule

// File: rtl/lcd_text_stream.sv
// ASCII byte stream -> LCD command/data bytes with cursor tracking; output one cycle after a FIFO pop.
// Input stalls via CHAR_READY when the FIFO is full; LCD_TEXT_STREAM_DEBUG_EN adds a registered LED port.
module lcd_text_stream
  import lcd_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter int         LINE_LEN   = 16,
  parameter logic [7:0] LINE1_ADDR = LCD_LINE1,
  parameter logic [7:0] LINE2_ADDR = LCD_LINE2,
  parameter logic [7:0] CLEAR_CMD  = LCD_CLEAR
) (
  input  logic       CLOCK_50MHZ,
  input  logic       RESET_N,
  input  logic       CHAR_VALID,
  output logic       CHAR_READY,
  input  logic [7:0] CHAR_DATA,
  output logic       CMD_VALID,
  input  logic       CMD_READY,
  output logic       CMD_RS,
  output logic [7:0] CMD_DATA,
  output logic [4:0] CURSOR_POS,
  output logic       BUSY
`ifdef LCD_TEXT_STREAM_DEBUG_EN
  ,
  output logic [7:0] LED
`endif
);

  state_t     state;
  logic       ready_en, push, pop, full, empty, xfer, addr_pending;
  logic [7:0] head, chr, line_addr;
  logic [4:0] pos_inc;

  assign CHAR_READY = ready_en && !full;
  assign push       = CHAR_VALID && CHAR_READY;
  assign pop        = (state == IDLE) && !empty;
  assign xfer       = CMD_VALID && CMD_READY;
  assign BUSY       = (state != IDLE) || !empty;
  assign pos_inc    = CURSOR_POS + 5'd1;
  assign line_addr  = ((CURSOR_POS < 5'(LINE_LEN)) ? LINE1_ADDR : LINE2_ADDR)
                    | {4'h0, CURSOR_POS[3:0]};

  lcd_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (CLOCK_50MHZ),
    .rst_n   (RESET_N),
    .push    (push),
    .wr_data (CHAR_DATA),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge CLOCK_50MHZ) begin
    if (!RESET_N) begin
      state        <= INIT_CLR;
      ready_en     <= 1'b0;
      CMD_VALID    <= 1'b0;
      CMD_RS       <= 1'b0;
      CMD_DATA     <= 8'h00;
      CURSOR_POS   <= 5'd0;
      addr_pending <= 1'b0;
      chr          <= 8'h00;
    end else begin
      ready_en <= 1'b1;
      case (state)
        INIT_CLR: begin
          if (!CMD_VALID) begin
            CMD_VALID <= 1'b1;
            CMD_RS    <= 1'b0;
            CMD_DATA  <= CLEAR_CMD;
          end else if (CMD_READY) begin
            CMD_DATA <= LINE1_ADDR;
            state    <= INIT_HOME;
          end
        end
        INIT_HOME: begin
          if (xfer) begin
            CMD_VALID    <= 1'b0;
            CURSOR_POS   <= 5'd0;
            addr_pending <= 1'b0;
            state        <= IDLE;
          end
        end
        IDLE: begin
          if (pop) begin
            if (is_printable(head)) begin
              chr       <= head;
              CMD_VALID <= 1'b1;
              if (addr_pending) begin
                CMD_RS   <= 1'b0;
                CMD_DATA <= line_addr;
                state    <= EMIT_ADDR;
              end else begin
                CMD_RS   <= 1'b1;
                CMD_DATA <= head;
                state    <= EMIT_CHAR;
              end
            end else if (head == ASCII_LF) begin
              CURSOR_POS   <= (CURSOR_POS < 5'(LINE_LEN)) ? 5'(LINE_LEN) : 5'd0;
              addr_pending <= 1'b1;
            end else if (head == ASCII_CR) begin
              CURSOR_POS   <= CURSOR_POS & 5'h10;
              addr_pending <= 1'b1;
            end else if (head == ASCII_FF) begin
              CMD_VALID <= 1'b1;
              CMD_RS    <= 1'b0;
              CMD_DATA  <= CLEAR_CMD;
              state     <= EMIT_CLR;
            end
          end
        end
        EMIT_ADDR: begin
          if (xfer) begin
            addr_pending <= 1'b0;
            CMD_RS       <= 1'b1;
            CMD_DATA     <= chr;
            state        <= EMIT_CHAR;
          end
        end
        EMIT_CHAR: begin
          // Crossing into column 0 of either line needs a fresh address first.
          if (xfer) begin
            CMD_VALID  <= 1'b0;
            CURSOR_POS <= pos_inc;
            if (pos_inc[3:0] == 4'h0)
              addr_pending <= 1'b1;
            state <= IDLE;
          end
        end
        EMIT_CLR: begin
          if (xfer) begin
            CMD_DATA <= LINE1_ADDR;
            state    <= INIT_HOME;
          end
        end
        default: state <= INIT_CLR;
      endcase
    end
  end

`ifdef LCD_TEXT_STREAM_DEBUG_EN
  always_ff @(posedge CLOCK_50MHZ) begin
    if (!RESET_N)
      LED <= 8'hFF;
    else
      LED <= {state, CURSOR_POS};
  end
`endif

endmodule

// File: tb/tb_lcd_text_stream.sv
// Directed bench for lcd_text_stream: init sequence, text, line wrap, control codes, stall, mid-stream reset.
module tb_lcd_text_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] char_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic [4:0] cursor_pos;
  logic       busy;
`ifdef LCD_TEXT_STREAM_DEBUG_EN
  logic [7:0] led;
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [8:0] log_q[$];

  lcd_text_stream dut (
    .CLOCK_50MHZ (clk),
    .RESET_N     (rst_n),
    .CHAR_VALID  (char_valid),
    .CHAR_READY  (char_ready),
    .CHAR_DATA   (char_data),
    .CMD_VALID   (cmd_valid),
    .CMD_READY   (cmd_ready),
    .CMD_RS      (cmd_rs),
    .CMD_DATA    (cmd_data),
    .CURSOR_POS  (cursor_pos),
    .BUSY        (busy)
`ifdef LCD_TEXT_STREAM_DEBUG_EN
    ,
    .LED         (led)
`endif
  );

  always #10 clk = ~clk;

  // Record every accepted transfer as {rs, data}.
  always @(posedge clk) begin
    if (rst_n && cmd_valid && cmd_ready)
      log_q.push_back({cmd_rs, cmd_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    char_data  = b;
    char_valid = 1'b1;
    while (!char_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", {31'h0, char_ready}, 32'h1);
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [8:0] exp);
    int n;
    logic [8:0] g;
    n = 0;
    while (log_q.size() == 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    g = '1;
    if (log_q.size() != 0)
      g = log_q.pop_front();
    check(tag, {23'h0, g}, {23'h0, exp});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || cmd_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_busy", {31'h0, busy}, 32'h0);
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++)
      @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_data  = 8'h00;
    cmd_ready  = 1'b1;
    cycles(3);

    // Reset state
    check("rst_char_ready", {31'h0, char_ready}, 32'h0);
    check("rst_cmd_valid",  {31'h0, cmd_valid},  32'h0);
    check("rst_cmd_rs",     {31'h0, cmd_rs},     32'h0);
    check("rst_cmd_data",   {24'h0, cmd_data},   32'h00);
    check("rst_cursor",     {27'h0, cursor_pos}, 32'h0);
    check("rst_busy",       {31'h0, busy},       32'h1);

    // Init sequence
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_char_ready", {31'h0, char_ready}, 32'h1);
    expect_out("init_clear", 9'h001);
    expect_out("init_home",  9'h080);
    wait_idle();
    check("init_cursor", {27'h0, cursor_pos}, 32'd0);

    // "Hi"
    push(8'h48);
    push(8'h69);
    expect_out("hi_H", 9'h148);
    expect_out("hi_i", 9'h169);
    wait_idle();
    check("hi_cursor", {27'h0, cursor_pos}, 32'd2);

    // Form feed re-homes
    push(8'h0C);
    expect_out("ff1_clear", 9'h001);
    expect_out("ff1_home",  9'h080);
    wait_idle();
    check("ff1_cursor", {27'h0, cursor_pos}, 32'd0);

    // 17 'A': line 1 fills, line 2 address, then char
    for (int i = 0; i < 17; i++)
      push(8'h41);
    for (int i = 0; i < 16; i++)
      expect_out("wrap_line1_A", 9'h141);
    expect_out("wrap_line2_addr", 9'h0C0);
    expect_out("wrap_line2_A", 9'h141);
    wait_idle();
    check("wrap_cursor17", {27'h0, cursor_pos}, 32'd17);

    // 15 more fill line 2; 33rd char returns to line 1
    for (int i = 0; i < 15; i++)
      push(8'h41);
    for (int i = 0; i < 15; i++)
      expect_out("wrap_line2_rest", 9'h141);
    wait_idle();
    check("wrap_cursor32", {27'h0, cursor_pos}, 32'd0);
    push(8'h42);
    expect_out("wrap33_addr", 9'h080);
    expect_out("wrap33_B",    9'h142);
    wait_idle();
    check("wrap33_cursor", {27'h0, cursor_pos}, 32'd1);

    // x LF y CR z FF
    push(8'h78);
    push(8'h0A);
    push(8'h79);
    expect_out("lf_x",    9'h178);
    expect_out("lf_addr", 9'h0C0);
    expect_out("lf_y",    9'h179);
    wait_idle();
    check("lf_cursor", {27'h0, cursor_pos}, 32'd17);
    push(8'h0D);
    push(8'h7A);
    expect_out("cr_addr", 9'h0C0);
    expect_out("cr_z",    9'h17A);
    wait_idle();
    check("cr_cursor", {27'h0, cursor_pos}, 32'd17);
    push(8'h0C);
    expect_out("ff2_clear", 9'h001);
    expect_out("ff2_home",  9'h080);
    wait_idle();
    check("ff2_cursor", {27'h0, cursor_pos}, 32'd0);

    // Non-printables are discarded
    push(8'h71);
    expect_out("ctl_q", 9'h171);
    push(8'h07);
    push(8'h7F);
    wait_idle();
    cycles(4);
    check("ctl_no_output", log_q.size(), 32'd0);
    check("ctl_cursor", {27'h0, cursor_pos}, 32'd1);

    // Stall: nine bytes accepted (one popped, eight buffered), tenth blocks
    cmd_ready = 1'b0;
    for (int i = 0; i < 9; i++)
      push(8'h30 + 8'(i));
    cycles(2);
    check("stall_char_ready", {31'h0, char_ready}, 32'h0);
    check("stall_cmd_valid",  {31'h0, cmd_valid},  32'h1);
    check("stall_cmd_rs",     {31'h0, cmd_rs},     32'h1);
    check("stall_cmd_data",   {24'h0, cmd_data},   32'h30);
    char_data  = 8'h39;
    char_valid = 1'b1;
    cycles(3);
    check("stall_still_blocked", {31'h0, char_ready}, 32'h0);
    check("stall_data_stable",   {24'h0, cmd_data},   32'h30);
    check("stall_no_transfer",   log_q.size(),        32'd0);
    cmd_ready = 1'b1;
    push(8'h39);
    for (int i = 0; i < 10; i++)
      expect_out("stall_order", 9'h130 + 9'(i));
    wait_idle();
    check("stall_cursor", {27'h0, cursor_pos}, 32'd11);
    check("stall_no_extra", log_q.size(), 32'd0);

    // Reset in the middle of a stalled stream
    cmd_ready = 1'b0;
    push(8'h61);
    push(8'h62);
    push(8'h63);
    cycles(2);
    check("mid_cmd_valid", {31'h0, cmd_valid}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_cmd_valid",  {31'h0, cmd_valid},  32'h0);
    check("mid_rst_cmd_data",   {24'h0, cmd_data},   32'h00);
    check("mid_rst_cmd_rs",     {31'h0, cmd_rs},     32'h0);
    check("mid_rst_cursor",     {27'h0, cursor_pos}, 32'h0);
    check("mid_rst_busy",       {31'h0, busy},       32'h1);
    check("mid_rst_char_ready", {31'h0, char_ready}, 32'h0);
    cycles(1);
    cmd_ready = 1'b1;
    rst_n     = 1'b1;
    expect_out("mid_reinit_clear", 9'h001);
    expect_out("mid_reinit_home",  9'h080);
    wait_idle();
    cycles(4);
    check("mid_fifo_flushed", log_q.size(), 32'd0);
    check("mid_cursor", {27'h0, cursor_pos}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
